// File: rtl/aexm_fwdctl.sv
// aexm decode/execute operand forwarding, load-use interlock
// and multicycle-execute stall controller.
module aexm_fwdctl #(
    parameter int REGW      = 5,
    parameter int FWD_DEPTH = 2,
    parameter int IDXW      = 1,
    parameter int MUL_LAT   = 3,
    parameter int BSF_LAT   = 2,
    parameter int DIV_LAT   = 32,
    parameter int CNTW      = 6
) (
    input  logic            gclk,
    input  logic            grst,
    input  logic            d_en,
    input  logic            dVALID,
    input  logic [REGW-1:0] dRA,
    input  logic [REGW-1:0] dRB,
    input  logic [REGW-1:0] dRD,
    input  logic            dWE,
    input  logic            dLOAD,
    input  logic            dIMMSEL,
    input  logic            dPCSEL,
    input  logic [1:0]      dCLS,
    input  logic            xSKIP,
    output logic [1:0]      xSELA,
    output logic [1:0]      xSELB,
    output logic [IDXW-1:0] xFWDA,
    output logic [IDXW-1:0] xFWDB,
    output logic            fSTALL,
    output logic            mBUSY,
    output logic            mDONE
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                           r_st, w_st_nx;
    logic [CNTW-1:0]                  r_cnt, w_cnt_nx, w_lat1;
    logic                             r_done, w_done_nx;
    logic [FWD_DEPTH-1:0]             r_vld, r_ld, w_vsq;
    logic [FWD_DEPTH-1:0][REGW-1:0]   r_rd;
    logic                             w_hita, w_hitb;
    logic [IDXW-1:0]                  w_idxa, w_idxb;
    logic                             w_lua, w_lub, w_luse;
    logic                             w_acc, w_new_v;
    logic [1:0]                       w_sela, w_selb;
    logic [IDXW-1:0]                  w_fwda, w_fwdb;

    // Scan oldest to youngest so the youngest match is left standing.
    always_comb begin
        w_hita = 1'b0;
        w_hitb = 1'b0;
        w_idxa = '0;
        w_idxb = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (r_vld[k] && r_rd[k] == dRA) begin
                w_hita = 1'b1;
                w_idxa = IDXW'(k);
            end
            if (r_vld[k] && r_rd[k] == dRB) begin
                w_hitb = 1'b1;
                w_idxb = IDXW'(k);
            end
        end
    end

    assign w_lua  = dVALID & !dPCSEL & w_hita & (w_idxa == '0) & r_ld[w_idxa];
    assign w_lub  = dVALID & !dIMMSEL & w_hitb & (w_idxb == '0) & r_ld[w_idxb];
    assign w_luse = w_lua | w_lub;
    assign mBUSY  = (r_st == BUSY);
    assign fSTALL = w_luse | mBUSY;
    assign mDONE  = r_done;
    assign w_acc  = d_en & dVALID & !fSTALL;
    assign w_new_v = dVALID & dWE & (dRD != '0);

    always_comb begin
        w_vsq    = r_vld;
        w_vsq[0] = r_vld[0] & !xSKIP;
    end

    always_comb begin
        w_sela = dPCSEL ? 2'd2 : (w_hita ? 2'd1 : 2'd0);
        w_selb = dIMMSEL ? 2'd2 : (w_hitb ? 2'd1 : 2'd0);
        w_fwda = (!dPCSEL && w_hita) ? w_idxa : '0;
        w_fwdb = (!dIMMSEL && w_hitb) ? w_idxb : '0;
    end

    always_comb begin
        case (dCLS)
            2'b01:   w_lat1 = CNTW'(MUL_LAT - 1);
            2'b10:   w_lat1 = CNTW'(BSF_LAT - 1);
            2'b11:   w_lat1 = CNTW'(DIV_LAT - 1);
            default: w_lat1 = '0;
        endcase
    end

    always_comb begin
        w_st_nx   = r_st;
        w_cnt_nx  = r_cnt;
        w_done_nx = 1'b0;
        case (r_st)
            IDLE: begin
                if (w_acc && dCLS != 2'b00) begin
                    if (w_lat1 != '0) begin
                        w_st_nx  = BUSY;
                        w_cnt_nx = w_lat1;
                    end else begin
                        w_done_nx = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (xSKIP) begin
                    w_st_nx  = IDLE;
                    w_cnt_nx = '0;
                end else if (d_en) begin
                    if (r_cnt <= CNTW'(1)) begin
                        w_st_nx   = IDLE;
                        w_cnt_nx  = '0;
                        w_done_nx = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - CNTW'(1);
                    end
                end
            end
            default: begin
                w_st_nx  = IDLE;
                w_cnt_nx = '0;
            end
        endcase
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_st   <= IDLE;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_st   <= w_st_nx;
            r_cnt  <= w_cnt_nx;
            r_done <= w_done_nx;
        end
    end

    // Slots are frozen while a multicycle op occupies X.
    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            r_vld <= '0;
            r_ld  <= '0;
            r_rd  <= '0;
        end else if (d_en && r_st == IDLE) begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                r_vld[k] <= w_vsq[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
            r_vld[0] <= w_acc & w_new_v;
            r_rd[0]  <= w_acc ? dRD : '0;
            r_ld[0]  <= w_acc & dLOAD;
        end else begin
            r_vld[0] <= w_vsq[0];
        end
    end

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            xSELA <= 2'd0;
            xSELB <= 2'd0;
            xFWDA <= '0;
            xFWDB <= '0;
        end else if (xSKIP || (d_en && !w_acc)) begin
            xSELA <= 2'd0;
            xSELB <= 2'd0;
            xFWDA <= '0;
            xFWDB <= '0;
        end else if (w_acc) begin
            xSELA <= w_sela;
            xSELB <= w_selb;
            xFWDA <= w_fwda;
            xFWDB <= w_fwdb;
        end
    end

endmodule

// File: tb/tb_aexm_fwdctl.sv
// Directed-vector bench for aexm_fwdctl: forwarding, load-use,
// multicycle stall, squash and asynchronous reset.
module tb_aexm_fwdctl;

    logic       gclk = 1'b0;
    logic       grst;
    logic       d_en;
    logic       dVALID;
    logic [4:0] dRA, dRB, dRD;
    logic       dWE, dLOAD, dIMMSEL, dPCSEL;
    logic [1:0] dCLS;
    logic       xSKIP;
    logic [1:0] xSELA, xSELB;
    logic       xFWDA, xFWDB;
    logic       fSTALL, mBUSY, mDONE;

    int n_pass = 0;
    int n_tot  = 0;

    aexm_fwdctl dut (
        .gclk(gclk), .grst(grst), .d_en(d_en), .dVALID(dVALID),
        .dRA(dRA), .dRB(dRB), .dRD(dRD), .dWE(dWE), .dLOAD(dLOAD),
        .dIMMSEL(dIMMSEL), .dPCSEL(dPCSEL), .dCLS(dCLS), .xSKIP(xSKIP),
        .xSELA(xSELA), .xSELB(xSELB), .xFWDA(xFWDA), .xFWDB(xFWDB),
        .fSTALL(fSTALL), .mBUSY(mBUSY), .mDONE(mDONE)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic drv(input logic v, input int ra, input int rb,
                       input int rd, input logic we, input logic ld,
                       input logic imm, input logic pc,
                       input logic [1:0] cls);
        dVALID  = v;
        dRA     = 5'(ra);
        dRB     = 5'(rb);
        dRD     = 5'(rd);
        dWE     = we;
        dLOAD   = ld;
        dIMMSEL = imm;
        dPCSEL  = pc;
        dCLS    = cls;
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    int n;
    int done;

    initial begin
        grst  = 1'b0;
        d_en  = 1'b1;
        xSKIP = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        #12;
        chk("rst_sela", xSELA, 0);
        chk("rst_selb", xSELB, 0);
        chk("rst_fwda", xFWDA, 0);
        chk("rst_stall", fSTALL, 0);
        chk("rst_busy", mBUSY, 0);
        chk("rst_done", mDONE, 0);
        grst = 1'b1;
        tick();

        // ALU forward from slot 0
        drv(1, 1, 2, 3, 1, 0, 0, 0, 2'b00);
        tick();
        drv(1, 3, 4, 5, 1, 0, 0, 0, 2'b00);
        #1 chk("alu_nostall", fSTALL, 0);
        tick();
        chk("alu_sela", xSELA, 1);
        chk("alu_fwda", xFWDA, 0);
        chk("alu_selb", xSELB, 0);

        // load-use: one bubble, then forward from slot 1
        drv(1, 1, 0, 3, 1, 1, 1, 0, 2'b00);
        tick();
        drv(1, 3, 3, 5, 1, 0, 0, 0, 2'b00);
        #1 chk("lu_stall", fSTALL, 1);
        tick();
        chk("lu_clear", fSTALL, 0);
        chk("lu_bubble", xSELA, 0);
        tick();
        chk("lu_sela", xSELA, 1);
        chk("lu_selb", xSELB, 1);
        chk("lu_fwda", xFWDA, 1);
        chk("lu_fwdb", xFWDB, 1);

        // r0 never forwarded
        drv(1, 1, 2, 0, 1, 0, 0, 0, 2'b00);
        tick();
        drv(1, 0, 0, 6, 1, 0, 0, 0, 2'b00);
        tick();
        chk("r0_sela", xSELA, 0);
        chk("r0_selb", xSELB, 0);

        // youngest writer wins
        drv(1, 1, 2, 3, 1, 0, 0, 0, 2'b00);
        tick();
        drv(1, 1, 2, 3, 1, 0, 0, 0, 2'b00);
        tick();
        drv(1, 3, 3, 6, 1, 0, 0, 0, 2'b00);
        tick();
        chk("pri_sela", xSELA, 1);
        chk("pri_fwda", xFWDA, 0);
        chk("pri_fwdb", xFWDB, 0);

        // PC / immediate selects
        drv(1, 3, 3, 6, 1, 0, 1, 1, 2'b00);
        tick();
        chk("pc_sela", xSELA, 2);
        chk("imm_selb", xSELB, 2);

        // immediate B hides a load on rb
        drv(1, 1, 0, 11, 1, 1, 1, 0, 2'b00);
        tick();
        drv(1, 1, 11, 12, 1, 0, 1, 0, 2'b00);
        #1 chk("imm_nolu", fSTALL, 0);
        tick();

        // MUL: LAT-1 stall cycles, one mDONE
        drv(1, 1, 2, 7, 1, 0, 0, 0, 2'b01);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        chk("mul_busy", mBUSY, 1);
        n = 0;
        done = 0;
        while (fSTALL && n < 100) begin
            tick();
            n++;
            done += int'(mDONE);
        end
        drv(1, 7, 2, 13, 1, 0, 0, 0, 2'b00);
        tick();
        done += int'(mDONE);
        chk("mul_stall", n, 2);
        chk("mul_done", done, 1);
        chk("mul_idle", mBUSY, 0);
        chk("mul_fwd_sel", xSELA, 1);
        chk("mul_fwd_idx", xFWDA, 0);

        // DIV with d_en low for 5 cycles mid-op
        drv(1, 1, 2, 8, 1, 0, 0, 0, 2'b11);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        n = 0;
        done = 0;
        while (fSTALL && n < 200) begin
            if (n == 10) d_en = 1'b0;
            if (n == 15) d_en = 1'b1;
            tick();
            n++;
            done += int'(mDONE);
        end
        d_en = 1'b1;
        tick();
        done += int'(mDONE);
        chk("div_stall", n, 36);
        chk("div_done", done, 1);

        // squash a MUL in X
        drv(1, 8, 2, 9, 1, 0, 0, 0, 2'b01);
        tick();
        chk("sq_busy", mBUSY, 1);
        chk("sq_pre_sela", xSELA, 1);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        xSKIP = 1'b1;
        tick();
        xSKIP = 1'b0;
        chk("sq_abort", mBUSY, 0);
        chk("sq_nostall", fSTALL, 0);
        chk("sq_sela", xSELA, 0);
        drv(1, 9, 9, 14, 1, 0, 0, 0, 2'b00);
        tick();
        chk("sq_rd_sela", xSELA, 0);
        chk("sq_rd_selb", xSELB, 0);
        chk("sq_nodone", mDONE, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        chk("sq_nodone2", mDONE, 0);

        // async reset mid-DIV at cnt == 17
        drv(1, 1, 2, 10, 1, 0, 0, 0, 2'b11);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        repeat (14) tick();
        chk("rst_pre_busy", mBUSY, 1);
        #2 grst = 1'b0;
        #1;
        chk("arst_stall", fSTALL, 0);
        chk("arst_busy", mBUSY, 0);
        chk("arst_sela", xSELA, 0);
        chk("arst_done", mDONE, 0);
        @(posedge gclk);
        #1 grst = 1'b1;
        tick();
        chk("arst_done2", mDONE, 0);
        chk("arst_busy2", mBUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
